// File: rtl/delay_timer_bank.sv
// Multi-channel programmable delay generator driven by one shared prescaler tick.
// Optional HUD countdown output is enabled with `define DELAY_TIMER_REMAIN_EN.
module delay_timer_bank #(
    parameter int CHANNELS      = 4,
    parameter int DELAY_BITS    = 8,
    parameter int PRESCALE_BITS = 16,
    parameter int PRESCALE_MAX  = 49999
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            enable,
    input  logic [CHANNELS-1:0]            periodic,
    input  logic [CHANNELS-1:0]            load,
    input  logic [CHANNELS*DELAY_BITS-1:0] delay,
    output logic [CHANNELS-1:0]            waiting,
`ifdef DELAY_TIMER_REMAIN_EN
    output logic [CHANNELS*DELAY_BITS-1:0] remaining,
`endif
    output logic [CHANNELS-1:0]            done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam logic [PRESCALE_BITS-1:0] PRE_MAX = PRESCALE_BITS'(PRESCALE_MAX);

    logic [PRESCALE_BITS-1:0] pre_cnt_q, pre_cnt_d;
    logic                     base_tick;

    state_t                state_q  [CHANNELS];
    state_t                state_d  [CHANNELS];
    logic [DELAY_BITS-1:0] cnt_q    [CHANNELS];
    logic [DELAY_BITS-1:0] cnt_d    [CHANNELS];
    logic [DELAY_BITS-1:0] reload_q [CHANNELS];
    logic [DELAY_BITS-1:0] reload_d [CHANNELS];
    logic [CHANNELS-1:0]   mode_q, mode_d;
    logic [CHANNELS-1:0]   waiting_q, waiting_d;
    logic [CHANNELS-1:0]   done_q, done_d;

    // Free-running prescaler: independent of enable/load by design.
    always_comb begin
        base_tick = (pre_cnt_q == PRE_MAX);
        pre_cnt_d = base_tick ? '0 : pre_cnt_q + PRESCALE_BITS'(1);
    end

    always_comb begin
        mode_d    = mode_q;
        waiting_d = '1;
        done_d    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            reload_d[i] = reload_q[i];
            // A load wins over a same-cycle expiry, so no done pulse is emitted.
            if (load[i]) begin
                reload_d[i] = delay[i*DELAY_BITS +: DELAY_BITS];
                mode_d[i]   = periodic[i];
                cnt_d[i]    = '0;
                state_d[i]  = ST_RUN;
            end else if (enable[i]) begin
                case (state_q[i])
                    ST_RUN: begin
                        if (base_tick) begin
                            if (cnt_q[i] == reload_q[i]) begin
                                done_d[i]    = 1'b1;
                                waiting_d[i] = 1'b0;
                                cnt_d[i]     = '0;
                                if (!mode_q[i]) begin
                                    state_d[i] = ST_EXPIRED;
                                end
                            end else begin
                                cnt_d[i] = cnt_q[i] + DELAY_BITS'(1);
                            end
                        end
                    end
                    ST_EXPIRED: waiting_d[i] = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_q <= '0;
            mode_q    <= '0;
            waiting_q <= '1;
            done_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= ST_IDLE;
                cnt_q[i]    <= '0;
                reload_q[i] <= '0;
            end
        end else begin
            pre_cnt_q <= pre_cnt_d;
            mode_q    <= mode_d;
            waiting_q <= waiting_d;
            done_q    <= done_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= state_d[i];
                cnt_q[i]    <= cnt_d[i];
                reload_q[i] <= reload_d[i];
            end
        end
    end

    assign waiting = waiting_q;
    assign done    = done_q;

`ifdef DELAY_TIMER_REMAIN_EN
    logic [CHANNELS*DELAY_BITS-1:0] remaining_q, remaining_d;

    // Computed from next-state values so it moves in step with the counter.
    always_comb begin
        remaining_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (state_d[i] == ST_RUN) begin
                remaining_d[i*DELAY_BITS +: DELAY_BITS] = reload_d[i] - cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining_q <= '0;
        end else begin
            remaining_q <= remaining_d;
        end
    end

    assign remaining = remaining_q;
`endif

endmodule

// File: tb/tb_delay_timer_bank.sv
// Self-checking bench for delay_timer_bank: a ticks-until-expiry model checked every
// cycle, plus directed scenarios with hand-computed cycle positions (prescale period 4).
module tb_delay_timer_bank;

    localparam int CH   = 4;
    localparam int DB   = 8;
    localparam int PMAX = 3;

    logic             clk;
    logic             reset;
    logic [CH-1:0]    enable;
    logic [CH-1:0]    periodic;
    logic [CH-1:0]    load;
    logic [CH*DB-1:0] dly;
    logic [CH-1:0]    waiting;
    logic [CH-1:0]    done;
`ifdef DELAY_TIMER_REMAIN_EN
    logic [CH*DB-1:0] remaining;
`endif

    delay_timer_bank #(
        .CHANNELS      (CH),
        .DELAY_BITS    (DB),
        .PRESCALE_BITS (16),
        .PRESCALE_MAX  (PMAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .periodic  (periodic),
        .load      (load),
        .delay     (dly),
        .waiting   (waiting),
`ifdef DELAY_TIMER_REMAIN_EN
        .remaining (remaining),
`endif
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each running channel tracks how many base ticks remain until expiry.
    int        clks;
    bit        mvalid = 1'b0;
    bit        m_active  [CH];
    bit        m_expired [CH];
    bit        m_mode    [CH];
    int        m_reload  [CH];
    int        m_left    [CH];
    logic [CH-1:0] exp_w, exp_d;

    always @(posedge clk) begin
        bit tick;
        if (reset) begin
            clks   = 0;
            exp_w  = '1;
            exp_d  = '0;
            mvalid = 1'b1;
            for (int c = 0; c < CH; c++) begin
                m_active[c]  = 1'b0;
                m_expired[c] = 1'b0;
                m_mode[c]    = 1'b0;
                m_reload[c]  = 0;
                m_left[c]    = 0;
            end
        end else begin
            tick = ((clks % (PMAX + 1)) == PMAX);
            clks++;
            for (int c = 0; c < CH; c++) begin
                exp_d[c] = 1'b0;
                exp_w[c] = 1'b1;
                if (load[c]) begin
                    m_active[c]  = 1'b1;
                    m_expired[c] = 1'b0;
                    m_mode[c]    = periodic[c];
                    m_reload[c]  = int'(dly[c*DB +: DB]);
                    m_left[c]    = m_reload[c] + 1;
                end else if (!enable[c]) begin
                    exp_w[c] = 1'b1;
                end else if (m_expired[c]) begin
                    exp_w[c] = 1'b0;
                end else if (m_active[c] && tick) begin
                    m_left[c]--;
                    if (m_left[c] == 0) begin
                        exp_d[c] = 1'b1;
                        exp_w[c] = 1'b0;
                        if (m_mode[c]) begin
                            m_left[c] = m_reload[c] + 1;
                        end else begin
                            m_active[c]  = 1'b0;
                            m_expired[c] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_waiting", 32'(waiting), 32'(exp_w));
            chk("model_done", 32'(done), 32'(exp_d));
`ifdef DELAY_TIMER_REMAIN_EN
            for (int c = 0; c < CH; c++) begin
                chk("model_remaining", 32'(remaining[c*DB +: DB]),
                    m_active[c] ? 32'(m_left[c] - 1) : 32'd0);
            end
`endif
        end
    end

    // Wait until the coming cycle has prescaler phase 0.
    task automatic align();
        while ((clks % (PMAX + 1)) != 0) @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        enable   = '0;
        periodic = '0;
        load     = '0;
        dly      = '0;
        repeat (3) @(negedge clk);
        chk("rst_waiting", 32'(waiting), 32'hf);
        chk("rst_done", 32'(done), 32'h0);

        // One-shot ch0, delay 2, loaded in the first cycle after reset (phase 0).
        reset       = 1'b0;
        enable      = '1;
        dly[7:0]    = 8'd2;
        periodic[0] = 1'b0;
        load[0]     = 1'b1;
        @(negedge clk);
        load = '0;
        for (int k = 1; k <= 15; k++) begin
            chk("oneshot_done", 32'(done[0]), 32'(k == 12));
            chk("oneshot_wait", 32'(waiting[0]), 32'(k < 12));
            @(negedge clk);
        end

        // Periodic ch1, delay 1: done every 8 clocks.
        align();
        dly[15:8]   = 8'd1;
        periodic[1] = 1'b1;
        load[1]     = 1'b1;
        @(negedge clk);
        load = '0;
        for (int k = 1; k <= 40; k++) begin
            chk("periodic_done", 32'(done[1]), 32'((k % 8) == 0));
            chk("periodic_wait", 32'(waiting[1]), 32'((k % 8) != 0));
            @(negedge clk);
        end

        // Freeze ch2, delay 3, disabled for 20 cycles: expiry moves from 16 to 36.
        align();
        dly[23:16]  = 8'd3;
        periodic[2] = 1'b0;
        load[2]     = 1'b1;
        @(negedge clk);
        load = '0;
        for (int k = 1; k <= 40; k++) begin
            chk("freeze_done", 32'(done[2]), 32'(k == 36));
            chk("freeze_wait", 32'(waiting[2]), 32'(k < 36));
            if (k == 6)  enable[2] = 1'b0;
            if (k == 26) enable[2] = 1'b1;
            @(negedge clk);
        end

        // Collision: reload ch0 with 5 in its expiry cycle; 6 new ticks follow.
        align();
        dly[7:0]    = 8'd2;
        periodic[0] = 1'b0;
        load[0]     = 1'b1;
        @(negedge clk);
        load = '0;
        for (int k = 1; k <= 40; k++) begin
            chk("collide_done", 32'(done[0]), 32'(k == 36));
            chk("collide_wait", 32'(waiting[0]), 32'(k < 36));
            if (k == 11) begin
                dly[7:0] = 8'd5;
                load[0]  = 1'b1;
            end
            if (k == 12) load[0] = 1'b0;
            @(negedge clk);
        end

        // Delay 0 on ch3 expires on the first base tick.
        align();
        dly[31:24]  = 8'd0;
        periodic[3] = 1'b0;
        load[3]     = 1'b1;
        @(negedge clk);
        load = '0;
        for (int k = 1; k <= 8; k++) begin
            chk("zero_done", 32'(done[3]), 32'(k == 4));
            chk("zero_wait", 32'(waiting[3]), 32'(k < 4));
`ifdef DELAY_TIMER_REMAIN_EN
            chk("zero_remaining", 32'(remaining[31:24]), 32'd0);
`endif
            @(negedge clk);
        end

        // Delay 4 on ch3: countdown 4,3,2,1,0 across base ticks.
        align();
        dly[31:24] = 8'd4;
        load[3]    = 1'b1;
        @(negedge clk);
        load = '0;
        for (int k = 1; k <= 24; k++) begin
            chk("cd_done", 32'(done[3]), 32'(k == 20));
            chk("cd_wait", 32'(waiting[3]), 32'(k < 20));
`ifdef DELAY_TIMER_REMAIN_EN
            chk("cd_remaining", 32'(remaining[31:24]), (k < 20) ? 32'(4 - k / 4) : 32'd0);
`endif
            @(negedge clk);
        end

        // Reset while all four channels are running.
        align();
        dly      = {8'd10, 8'd10, 8'd10, 8'd10};
        periodic = 4'b0010;
        load     = '1;
        @(negedge clk);
        load = '0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_waiting", 32'(waiting), 32'hf);
        chk("midrst_done", 32'(done), 32'h0);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'h0);
            chk("post_rst_wait", 32'(waiting), 32'hf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
